// File: rtl/conv1_layer_ctrl.sv
// rtl/conv1_layer_ctrl.sv - conv1 window sequencer: image/weight addressing, MAC control, output write handshake
module conv1_layer_ctrl #(
  parameter int IMG_W   = 28,
  parameter int K       = 5,
  parameter int K1_BASE = 25,
  parameter int IA_W    = 10,
  parameter int KA_W    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic [IA_W-1:0] img_addr,
  output logic [KA_W-1:0] k_addr0,
  output logic [KA_W-1:0] k_addr1,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            out_we,
  output logic [IA_W-1:0] out_addr
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int CW    = $clog2(IMG_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state;
  logic [CW-1:0]   row, col, ky, kx;
  logic [IA_W-1:0] img_cur, img_hold;
  logic [KA_W-1:0] tap, k0_hold, k1_hold;

  assign img_cur = (IA_W'(row) + IA_W'(ky)) * IA_W'(IMG_W) + IA_W'(col) + IA_W'(kx);
  assign tap     = KA_W'(ky) * KA_W'(K) + KA_W'(kx);

  // Addresses follow the tap counters only while reading; otherwise they hold the last tap issued.
  assign img_addr = (state == S_READ) ? img_cur : img_hold;
  assign k_addr0  = (state == S_READ) ? tap : k0_hold;
  assign k_addr1  = (state == S_READ) ? KA_W'(K1_BASE) + tap : k1_hold;
  assign out_addr = IA_W'(row) * IA_W'(OUT_W) + IA_W'(col);

  assign busy    = (state == S_CLEAR) || (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
  assign done    = (state == S_DONE);
  assign mac_clr = (state == S_CLEAR);
  assign out_we  = (state == S_WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_hold <= '0;
      k0_hold  <= '0;
      k1_hold  <= KA_W'(K1_BASE);
      mac_en   <= 1'b0;
    end else begin
      mac_en <= (state == S_READ);
      if (state == S_READ) begin
        img_hold <= img_addr;
        k0_hold  <= k_addr0;
        k1_hold  <= k_addr1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      ky    <= '0;
      kx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_CLEAR;
        end
        S_CLEAR: begin
          ky    <= '0;
          kx    <= '0;
          state <= S_READ;
        end
        S_READ: begin
          if (kx == CW'(K - 1)) begin
            kx <= '0;
            if (ky == CW'(K - 1)) begin
              ky    <= '0;
              state <= S_DRAIN;
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
        end
        S_DRAIN: begin
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (out_ready) begin
            if (col == CW'(OUT_W - 1)) begin
              col <= '0;
              if (row == CW'(OUT_W - 1)) begin
                row   <= '0;
                state <= S_DONE;
              end else begin
                row   <= row + 1'b1;
                state <= S_CLEAR;
              end
            end else begin
              col   <= col + 1'b1;
              state <= S_CLEAR;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
